// File: rtl/spi_mem_ctrl_if.sv
// rtl/spi_mem_ctrl_if.sv - core-side word request bus for the SPI memory controller
interface spi_mem_ctrl_if;
    logic        req;
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, done, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, done, busy
    );
endinterface

// File: rtl/spi_mem_ctrl.sv
// rtl/spi_mem_ctrl.sv - SPI mode-0 initiator moving 32-bit words to/from external SPI memory
module spi_mem_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    spi_mem_ctrl_if.slave  bus,
    output logic           spi_cs_n,
    output logic           spi_sclk,
    output logic           spi_mosi,
    input  logic           spi_miso
);
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nx;
    logic [63:0] shreg;
    logic [63:0] frame;
    logic [31:0] rx;
    logic [5:0]  bit_cnt;
    logic        we_q;
    logic        cs_n_nx, sclk_nx, busy_nx, done_nx;

    // Data bytes go out lowest address first; reads send zeros in the data phase.
    always_comb begin
        frame = {(bus.we ? CMD_WRITE : CMD_READ), bus.addr,
                 (bus.we ? {bus.wdata[7:0], bus.wdata[15:8], bus.wdata[23:16], bus.wdata[31:24]}
                         : 32'h0)};
    end

    always_comb begin
        state_nx = state;
        cs_n_nx  = 1'b1;
        sclk_nx  = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    state_nx = SHIFT;
                    cs_n_nx  = 1'b0;
                    busy_nx  = 1'b1;
                end
            end
            SHIFT: begin
                if (spi_sclk && bit_cnt == 6'd0) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end else begin
                    cs_n_nx = 1'b0;
                    busy_nx = 1'b1;
                    sclk_nx = ~spi_sclk;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            spi_cs_n  <= 1'b1;
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.rdata <= 32'h0;
            shreg     <= 64'h0;
            rx        <= 32'h0;
            bit_cnt   <= 6'd0;
            we_q      <= 1'b0;
        end else begin
            state    <= state_nx;
            spi_cs_n <= cs_n_nx;
            spi_sclk <= sclk_nx;
            bus.busy <= busy_nx;
            bus.done <= done_nx;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        shreg    <= frame;
                        we_q     <= bus.we;
                        bit_cnt  <= 6'd63;
                        spi_mosi <= frame[63];
                    end
                end
                SHIFT: begin
                    // sclk low phase ending: the edge raising sclk also captures MISO.
                    if (!spi_sclk) begin
                        rx <= {rx[30:0], spi_miso};
                    end else if (bit_cnt != 6'd0) begin
                        shreg    <= {shreg[62:0], 1'b0};
                        spi_mosi <= shreg[62];
                        bit_cnt  <= bit_cnt - 6'd1;
                    end else begin
                        spi_mosi <= 1'b0;
                        if (!we_q)
                            bus.rdata <= {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb/tb_spi_mem_ctrl.sv - self-checking bench for spi_mem_ctrl with SPI memory model
module tb_spi_mem_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_cs_n, spi_sclk, spi_mosi;
    logic spi_miso = 1'b0;

    always #5 clk = ~clk;

    spi_mem_ctrl_if bus ();

    spi_mem_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .spi_cs_n (spi_cs_n),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    logic [63:0] mon_bits = 64'h0;
    int          mon_rises = 0;
    logic [63:0] resp_bits = 64'h0;
    int          s_idx = 0;
    int          proto_err = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_mosi = 1'b0;
    logic [31:0] exp_rdata = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Bus monitor: every rising sclk edge latches one frame bit.
    always @(posedge spi_sclk) begin
        mon_bits = {mon_bits[62:0], spi_mosi};
        mon_rises++;
    end

    // SPI memory model: presents the next response bit after every falling sclk.
    always @(negedge spi_cs_n) begin
        mon_rises = 0;
        mon_bits  = 64'h0;
        s_idx     = 0;
        spi_miso  = resp_bits[63];
    end

    always @(negedge spi_sclk) begin
        if (!spi_cs_n) begin
            s_idx++;
            if (s_idx < 64) spi_miso = resp_bits[63 - s_idx];
        end
    end

    always @(negedge clk) begin
        if (prev_sclk === 1'b0 && spi_sclk === 1'b1 && spi_mosi !== prev_mosi) proto_err++;
        if (spi_cs_n === 1'b1 && spi_sclk !== 1'b0) proto_err++;
        prev_sclk = spi_sclk;
        prev_mosi = spi_mosi;
    end

    // resp lists the four bytes the memory returns, in stream order, as {b0,b1,b2,b3}.
    task automatic run_frame(input string name, input logic w, input logic [23:0] a,
                             input logic [31:0] d, input logic [31:0] resp, input int intrude);
        logic [7:0]  bytes [8];
        logic [63:0] exp_frame;
        logic [31:0] rd_at_done;
        int          done_cyc, n_done, n_cs, n_busy;
        bytes[0] = w ? 8'h02 : 8'h03;
        bytes[1] = a[23:16];
        bytes[2] = a[15:8];
        bytes[3] = a[7:0];
        for (int i = 0; i < 4; i++) bytes[4 + i] = w ? d[8 * i +: 8] : 8'h00;
        exp_frame = 64'h0;
        for (int i = 0; i < 8; i++) exp_frame = {exp_frame[55:0], bytes[i]};
        if (!w) begin
            exp_rdata = 32'h0;
            for (int i = 0; i < 4; i++) exp_rdata = exp_rdata | (32'(resp[31 - 8 * i -: 8]) << (8 * i));
        end
        resp_bits  = {$urandom(), resp};
        done_cyc   = 0;
        n_done     = 0;
        n_cs       = 0;
        n_busy     = 0;
        rd_at_done = 32'h0;
        @(negedge clk);
        proto_err = 0;
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.req = 1'b0;
        for (int c = 1; c <= 140; c++) begin
            if (c == intrude) begin
                bus.req = 1'b1; bus.we = ~w; bus.addr = ~a; bus.wdata = ~d;
            end else if (c == intrude + 1) begin
                bus.req = 1'b0;
            end
            if (bus.done === 1'b1) begin
                n_done++;
                if (done_cyc == 0) begin
                    done_cyc   = c;
                    rd_at_done = bus.rdata;
                end
            end
            if (spi_cs_n === 1'b0) n_cs++;
            if (bus.busy === 1'b1) n_busy++;
            @(negedge clk);
        end
        check({name, " done_cycle"}, 64'(done_cyc), 64'd129);
        check({name, " done_count"}, 64'(n_done), 64'd1);
        check({name, " cs_low_cycles"}, 64'(n_cs), 64'd128);
        check({name, " busy_cycles"}, 64'(n_busy), 64'd128);
        check({name, " mosi_frame"}, mon_bits, exp_frame);
        check({name, " sclk_rises"}, 64'(mon_rises), 64'd64);
        check({name, " protocol"}, 64'(proto_err), 64'd0);
        check({name, " rdata_done"}, 64'(rd_at_done), 64'(exp_rdata));
        check({name, " rdata_held"}, 64'(bus.rdata), 64'(exp_rdata));
    endtask

    initial begin
        int falls[$];
        int dones[$];
        int cs_hi, n_cs, n_done;
        logic prev_cs;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 24'h0; bus.wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst cs_n", 64'(spi_cs_n), 64'd1);
        check("rst sclk", 64'(spi_sclk), 64'd0);
        check("rst mosi", 64'(spi_mosi), 64'd0);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst rdata", 64'(bus.rdata), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame("wr_dir", 1'b1, 24'h001234, 32'hDEADBEEF, 32'h5A5A5A5A, 0);
        run_frame("rd_dir", 1'b0, 24'hABCDEF, 32'h0, 32'h11223344, 0);
        run_frame("wr_intr50", 1'b1, 24'h00BEEF, 32'h01234567, 32'h0, 50);
        run_frame("rd_intr129", 1'b0, 24'h123456, 32'h0, 32'hCAFEF00D, 129);
        for (int k = 0; k < 4; k++)
            run_frame($sformatf("rand%0d", k), 1'(k), 24'($urandom()), $urandom(), $urandom(), 0);

        // Reset in the middle of a frame.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 24'h777777;
        @(negedge clk);
        bus.req = 1'b0;
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst cs_n", 64'(spi_cs_n), 64'd1);
        check("midrst sclk", 64'(spi_sclk), 64'd0);
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst done", 64'(bus.done), 64'd0);
        check("midrst rdata", 64'(bus.rdata), 64'd0);
        exp_rdata = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_cs = 0;
        n_done = 0;
        repeat (200) begin
            @(negedge clk);
            if (spi_cs_n !== 1'b1) n_cs++;
            if (bus.done === 1'b1) n_done++;
        end
        check("postrst cs_low", 64'(n_cs), 64'd0);
        check("postrst done", 64'(n_done), 64'd0);

        // Back-to-back with req held high.
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 24'h000100; bus.wdata = 32'h89ABCDEF;
        @(negedge clk);
        prev_cs = 1'b1;
        cs_hi = 0;
        for (int c = 1; c <= 300; c++) begin
            if (prev_cs === 1'b1 && spi_cs_n === 1'b0) falls.push_back(c);
            if (c < 259 && spi_cs_n === 1'b1) cs_hi++;
            if (bus.done === 1'b1) begin
                dones.push_back(c);
                if (dones.size() == 2) bus.req = 1'b0;
            end
            prev_cs = spi_cs_n;
            @(negedge clk);
        end
        bus.req = 1'b0;
        check("b2b falls", 64'(falls.size()), 64'd2);
        check("b2b dones", 64'(dones.size()), 64'd2);
        if (falls.size() == 2) check("b2b second_fall", 64'(falls[1]), 64'd131);
        if (dones.size() == 2) begin
            check("b2b done1", 64'(dones[0]), 64'd129);
            check("b2b done_gap", 64'(dones[1] - dones[0]), 64'd130);
        end
        check("b2b cs_gap", 64'(cs_hi), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
